sobel_window_buffer: RTL and testbench
======================================

# sobel_window_buffer

Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel control stage. It accepts one grayscale pixel per cycle in raster order through a valid/ready handshake and buffers the two previous image rows in line buffers. Each time a full 3x3 window becomes available, it presents all nine pixels in parallel. This removes the per-pixel window preparation from the SPI path: the SPI front end (or a pixel source) pushes raw pixels, and the Sobel stage consumes complete windows.

## Interface
- PIXEL_WIDTH, 8, bits per grayscale pixel
- IMG_WIDTH, 16, columns per row (≥3)
- IMG_HEIGHT, 16, rows per frame (≥3)
- clk_i  in  1  single clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous frame abort; same effect as reset_i on counters and outputs
- px_valid_i  in  1  input pixel valid
- px_ready_o  out  1  block can accept a pixel this cycle
- px_i  in  PIXEL_WIDTH  grayscale pixel, raster order
- win_valid_o  out  1  window_o holds a valid window
- win_ready_i  in  1  downstream accepts window this cycle
- window_o  out  9*PIXEL_WIDTH  3x3 window; slot k = window_o[k*PIXEL_WIDTH +: PIXEL_WIDTH], k = 3*r + c; r=0 is the oldest row, c=0 is the oldest column; k=8 is the newest pixel
- frame_done_o  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Accept: a pixel is accepted when px_valid_i && px_ready_o.
- Ready rule: px_ready_o = !win_valid_o || win_ready_i (one-deep output, combinational ready).
- Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) track the position of the next pixel. On accept, col increments. When col is IMG_WIDTH-1 it wraps to 0 and row increments. When row is IMG_HEIGHT-1 and col is IMG_WIDTH-1, both wrap to 0 (next frame).
- Line buffers: two arrays of IMG_WIDTH entries, lb_old (row-2) and lb_mid (row-1). On accept at column col:
  - top = lb_old[col], mid = lb_mid[col]
  - lb_old[col] <= lb_mid[col]
  - lb_mid[col] <= px_i
- Window shift: on accept, column slots shift left (c0<=c1, c1<=c2) and the new column {top, mid, px_i} loads into c2 for rows 0, 1 and 2.
- Window emission:
  - win_valid_o is set on accept when row≥2 and col≥2, so the window is centred on (row-1, col-1). No border padding is applied.
  - win_valid_o clears on win_ready_i when the same cycle does not accept a new emitting pixel.
  - Accept and hand-off in the same cycle: win_valid_o stays 1 and window_o updates.
- Hold: window_o is stable while win_valid_o && !win_ready_i.
- Frame completion: frame_done_o pulses when the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted. That pixel also emits the last window.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- No arithmetic on pixel values; data passes through unmodified.
- Reset / clear:
  - row, col, win_valid_o and frame_done_o go to 0.
  - window_o slots go to 0.
  - Line buffer contents are not reset. They are never emitted before being overwritten by the current frame.
  - clear_i has priority over a simultaneous accept; the pixel is dropped.
- Reset mid-operation: any pending window is discarded and the next accepted pixel is treated as (0,0).

## Timing
- Latency: window_o and win_valid_o update one cycle after the accepting edge (registered).
- Throughput: one pixel per cycle while win_ready_i is held at 1.
- frame_done_o is asserted in the same cycle as the final window's win_valid_o rising.
- Stalling: px_ready_o falls in the same cycle that win_ready_i falls while win_valid_o=1. No pixel is lost or duplicated.
- Reset values: px_ready_o=1, win_valid_o=0, frame_done_o=0, window_o=0.
- Combinational paths: px_ready_o depends combinationally on win_ready_i only. No other combinational input-to-output paths exist.

## Test plan
- Basic fill: IMG_WIDTH=IMG_HEIGHT=4, px=16*row+col, win_ready_i=1. Required response:
  - The first window follows the 11th pixel (row 2, col 2) with slots 0..8 = 0,1,2,16,17,18,32,33,34.
  - Exactly 4 windows are emitted; the last is 17,18,19,33,34,35,49,50,51.
  - frame_done_o pulses once, together with the last window.
- Backpressure: same stream with win_ready_i toggling 1,0,0,1…. Required response:
  - px_ready_o is 0 during stalls.
  - window_o is held constant while stalled.
  - The window sequence is identical to the basic-fill case.
- Back-to-back frames: two 4x4 frames streamed with no gap (second frame px=100+16*row+col). Required response:
  - 8 windows total; the 5th is 100,101,102,116,117,118,132,133,134.
  - Two frame_done_o pulses.
- Reset mid-frame: assert reset_i after pixel (2,1) of a 4x4 frame, then restart the stream from (0,0). Required response:
  - No window is emitted before the restarted stream's 11th pixel.
  - The first window is 0,1,2,16,17,18,32,33,34.
- Clear with simultaneous accept: clear_i=1 while px_valid_i=1 and a window is pending. Required response:
  - The pixel is dropped and win_valid_o=0 on the next cycle.
  - The next pixel is counted as (0,0).
- Input gaps: px_valid_i deasserted randomly for 0–3 cycles. Required response:
  - Windows and order match the basic-fill case.
  - win_valid_o does not rise for cycles without an accept.

Source files
------------

// File: rtl/sobel_window_buffer.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// emitting one full neighbourhood per accepted pixel once row>=2 and col>=2.
module sobel_window_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     px_valid_i,
  output logic                     px_ready_o,
  input  logic [PIXEL_WIDTH-1:0]   px_i,
  output logic                     win_valid_o,
  input  logic                     win_ready_i,
  output logic [9*PIXEL_WIDTH-1:0] window_o,
  output logic                     frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LastCol = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LastRow = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] ColTwo  = CW'(2);
  localparam logic [RW-1:0] RowTwo  = RW'(2);

  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     winValid_q, winValid_d;
  logic                     frameDone_q, frameDone_d;
  logic [9*PIXEL_WIDTH-1:0] window_q, window_d;

  logic [PIXEL_WIDTH-1:0]   lbOld [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0]   lbMid [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0]   newCol [3];

  logic accept;
  logic emit;
  logic lastPixel;
  logic flush;

  assign px_ready_o   = !winValid_q || win_ready_i;
  assign accept       = px_valid_i && px_ready_o;
  assign flush        = reset_i || clear_i;
  assign emit         = accept && (row_q >= RowTwo) && (col_q >= ColTwo);
  assign lastPixel    = (row_q == LastRow) && (col_q == LastCol);

  assign newCol[0]    = lbOld[col_q];
  assign newCol[1]    = lbMid[col_q];
  assign newCol[2]    = px_i;

  assign win_valid_o  = winValid_q;
  assign window_o     = window_q;
  assign frame_done_o = frameDone_q;

  // Accepted pixels shift the window left and advance the raster position.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    winValid_d  = winValid_q;
    frameDone_d = 1'b0;
    window_d    = window_q;
    if (win_ready_i) begin
      winValid_d = 1'b0;
    end
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        window_d[(3*r)*PIXEL_WIDTH +: PIXEL_WIDTH]   = window_q[(3*r+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
        window_d[(3*r+1)*PIXEL_WIDTH +: PIXEL_WIDTH] = window_q[(3*r+2)*PIXEL_WIDTH +: PIXEL_WIDTH];
        window_d[(3*r+2)*PIXEL_WIDTH +: PIXEL_WIDTH] = newCol[r];
      end
      if (emit) begin
        winValid_d = 1'b1;
      end
      frameDone_d = lastPixel;
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = (row_q == LastRow) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      col_q       <= '0;
      row_q       <= '0;
      winValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
      window_q    <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      winValid_q  <= winValid_d;
      frameDone_q <= frameDone_d;
      window_q    <= window_d;
    end
  end

  // Line buffers hold no reset; stale entries are overwritten before use.
  always_ff @(posedge clk_i) begin
    if (accept && !flush) begin
      lbOld[col_q] <= lbMid[col_q];
      lbMid[col_q] <= px_i;
    end
  end

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Self-checking bench: an image-array model predicts every window, with
// literal windows from the 4x4 test plan pinning the model itself.
module tb_sobel_window_buffer;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk_i       = 1'b0;
  logic          reset_i     = 1'b1;
  logic          clear_i     = 1'b0;
  logic          px_valid_i  = 1'b0;
  logic          px_ready_o;
  logic [PW-1:0] px_i        = '0;
  logic          win_valid_o;
  logic          win_ready_i = 1'b1;
  logic [9*PW-1:0] window_o;
  logic          frame_done_o;

  int checks   = 0;
  int failures = 0;

  logic [71:0] handoffQ[$];
  logic [71:0] basicQ[$];
  int          doneCount = 0;

  logic [PW-1:0] img [H][W];
  int            mRow     = 0;
  int            mCol     = 0;
  logic          expValid = 1'b0;
  logic          expDone  = 1'b0;
  logic [71:0]   expWin   = '0;

  int readyMode = 0;
  int phaseCnt  = 0;
  bit gapMode   = 1'b0;

  sobel_window_buffer #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (clear_i),
    .px_valid_i   (px_valid_i),
    .px_ready_o   (px_ready_o),
    .px_i         (px_i),
    .win_valid_o  (win_valid_o),
    .win_ready_i  (win_ready_i),
    .window_o     (window_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [71:0] mkWin(input int b0, input int b1, input int b2,
                                        input int b3, input int b4, input int b5,
                                        input int b6, input int b7, input int b8);
    logic [71:0] w;
    w = {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    return w;
  endfunction

  function automatic logic [71:0] qAt(input int idx);
    if (idx < handoffQ.size()) return handoffQ[idx];
    return '1;
  endfunction

  // Compare against the model, then advance the model by what the next edge accepts.
  always @(negedge clk_i) begin
    bit acc;
    checkOutput("win_valid", 72'(win_valid_o), 72'(expValid));
    checkOutput("frame_done", 72'(frame_done_o), 72'(expDone));
    checkOutput("px_ready", 72'(px_ready_o), 72'(!expValid || win_ready_i));
    if (expValid && win_valid_o) checkOutput("window", window_o, expWin);
    if (win_valid_o && win_ready_i && !reset_i && !clear_i) handoffQ.push_back(window_o);
    if (frame_done_o) doneCount++;

    if (reset_i || clear_i) begin
      mRow     = 0;
      mCol     = 0;
      expValid = 1'b0;
      expDone  = 1'b0;
    end else begin
      acc     = px_valid_i && (!expValid || win_ready_i);
      expDone = 1'b0;
      if (win_ready_i) expValid = 1'b0;
      if (acc) begin
        img[mRow][mCol] = px_i;
        if (mRow >= 2 && mCol >= 2) begin
          expValid = 1'b1;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              expWin[(3*r+c)*8 +: 8] = img[mRow-2+r][mCol-2+c];
        end
        expDone = (mRow == H-1) && (mCol == W-1);
        mCol++;
        if (mCol == W) begin
          mCol = 0;
          mRow++;
          if (mRow == H) mRow = 0;
        end
      end
    end
  end

  task automatic setReady();
    phaseCnt++;
    case (readyMode)
      0: win_ready_i = 1'b1;
      1: win_ready_i = ((phaseCnt % 4) == 0) || ((phaseCnt % 4) == 3);
      default: win_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic applyStimulus(input int base, input bit randPix, input int npix);
    for (int i = 0; i < npix; i++) begin
      bit got;
      int waits;
      if (gapMode) begin
        repeat ($urandom_range(0, 3)) begin
          px_valid_i = 1'b0;
          setReady();
          @(posedge clk_i); #1;
        end
      end
      px_valid_i = 1'b1;
      px_i = randPix ? 8'($urandom) : 8'(base + 16*(i / W) + (i % W));
      got = 1'b0;
      waits = 0;
      while (!got && waits < 64) begin
        setReady();
        @(negedge clk_i);
        got = px_ready_o;
        @(posedge clk_i); #1;
        waits++;
      end
      if (!got) begin
        checkOutput("accept_timeout", 72'd0, 72'd1);
        px_valid_i = 1'b0;
        return;
      end
    end
    px_valid_i = 1'b0;
  endtask

  task automatic drain();
    px_valid_i  = 1'b0;
    win_ready_i = 1'b1;
    repeat (6) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic startPhase(input int rdy, input bit gaps);
    handoffQ.delete();
    doneCount = 0;
    readyMode = rdy;
    gapMode   = gaps;
    phaseCnt  = 0;
  endtask

  task automatic checkAgainstBasic(input string name);
    checkOutput({name, "_count"}, 72'(handoffQ.size()), 72'(basicQ.size()));
    for (int i = 0; i < basicQ.size(); i++) checkOutput({name, "_win"}, qAt(i), basicQ[i]);
  endtask

  initial begin
    logic [71:0] firstWin;
    logic [71:0] lastWin;
    firstWin = mkWin(0, 1, 2, 16, 17, 18, 32, 33, 34);
    lastWin  = mkWin(17, 18, 19, 33, 34, 35, 49, 50, 51);

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_px_ready", 72'(px_ready_o), 72'd1);
    checkOutput("reset_win_valid", 72'(win_valid_o), 72'd0);
    checkOutput("reset_frame_done", 72'(frame_done_o), 72'd0);
    checkOutput("reset_window", window_o, 72'd0);
    reset_i = 1'b0;

    startPhase(0, 1'b0);
    applyStimulus(0, 1'b0, 16);
    drain();
    checkOutput("basic_count", 72'(handoffQ.size()), 72'd4);
    checkOutput("basic_first", qAt(0), firstWin);
    checkOutput("basic_last", qAt(3), lastWin);
    checkOutput("basic_done", 72'(doneCount), 72'd1);
    basicQ = handoffQ;

    startPhase(1, 1'b0);
    applyStimulus(0, 1'b0, 16);
    drain();
    checkAgainstBasic("backpressure");
    checkOutput("backpressure_done", 72'(doneCount), 72'd1);

    startPhase(0, 1'b0);
    applyStimulus(0, 1'b0, 16);
    applyStimulus(100, 1'b0, 16);
    drain();
    checkOutput("b2b_count", 72'(handoffQ.size()), 72'd8);
    checkOutput("b2b_fifth", qAt(4), mkWin(100, 101, 102, 116, 117, 118, 132, 133, 134));
    checkOutput("b2b_done", 72'(doneCount), 72'd2);

    startPhase(0, 1'b0);
    applyStimulus(0, 1'b0, 10);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    checkOutput("midreset_valid", 72'(win_valid_o), 72'd0);
    applyStimulus(0, 1'b0, 16);
    drain();
    checkOutput("midreset_count", 72'(handoffQ.size()), 72'd4);
    checkOutput("midreset_first", qAt(0), firstWin);

    startPhase(0, 1'b0);
    applyStimulus(0, 1'b0, 11);
    checkOutput("clear_pending", 72'(win_valid_o), 72'd1);
    clear_i     = 1'b1;
    px_valid_i  = 1'b1;
    px_i        = 8'hAA;
    win_ready_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i    = 1'b0;
    px_valid_i = 1'b0;
    checkOutput("clear_valid", 72'(win_valid_o), 72'd0);
    startPhase(0, 1'b0);
    applyStimulus(0, 1'b0, 16);
    drain();
    checkOutput("clear_count", 72'(handoffQ.size()), 72'd4);
    checkOutput("clear_first", qAt(0), firstWin);
    checkOutput("clear_done", 72'(doneCount), 72'd1);

    startPhase(0, 1'b1);
    applyStimulus(0, 1'b0, 16);
    drain();
    checkAgainstBasic("gaps");

    startPhase(2, 1'b1);
    applyStimulus(0, 1'b1, 16);
    applyStimulus(0, 1'b1, 16);
    applyStimulus(0, 1'b1, 16);
    drain();
    checkOutput("random_count", 72'(handoffQ.size()), 72'd12);
    checkOutput("random_done", 72'(doneCount), 72'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
